// File: rtl/risc_pkg.sv
// Shared core parameters for the integer register file and its pending-write scoreboard.
package risc_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // Index 0 is hardwired to zero and is never written or marked pending.
  function automatic logic is_real_reg(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
// With REGFILE_BYPASS_EN a source being written back this cycle does not stall.
module reg_scoreboard
  import risc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   pending
);

  reg_mask_t pending_q;
  reg_mask_t pending_d;
  logic      rs1_hit;
  logic      rs2_hit;

  // Clear first, then set, so a same-cycle issue to the written register wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (issue_en && is_real_reg(issue_addr)) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs1_hit = pending_q[rs1_addr] & ~(wb_en && (wb_addr == rs1_addr));
    rs2_hit = pending_q[rs2_addr] & ~(wb_en && (wb_addr == rs2_addr));
  end
`else
  always_comb begin
    rs1_hit = pending_q[rs1_addr];
    rs2_hit = pending_q[rs2_addr];
  end
`endif

  assign stall   = rs1_hit | rs2_hit;
  assign pending = pending_q;

endmodule

// File: rtl/register_file.sv
// 32x32 register file with combinational reads, pending-write scoreboard and stall output.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module register_file
  import risc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   pending
);

  data_t regs_q [NUM_REGS];
  logic  wr_en_d;

  assign wr_en_d = wb_en && is_real_reg(wb_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Slot 0 is never written, but reads are still forced to zero explicitly.
  always_comb begin
    rs1_data = is_real_reg(rs1_addr) ? regs_q[rs1_addr] : '0;
    rs2_data = is_real_reg(rs2_addr) ? regs_q[rs2_addr] : '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en_d && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end
    if (wr_en_d && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end
`endif
  end

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .stall      (stall),
    .pending    (pending)
  );

endmodule
